sha_result_checker: RTL and testbench

//  Downstream consumer of sha256_2_pipeline: takes each valid_out/digest_out, rebuilds the nonce that produced it,
//  and compares the hash against the job target. Winning (nonce, digest) pairs go into a small result FIFO for the

---
 rtl/sha_pkg.sv | 19 +
 rtl/sha_result_checker_if.sv | 30 +++
 rtl/sha_result_fifo.sv | 63 ++++++
 rtl/sha_result_checker.sv | 117 +++++++++++
 tb/tb_sha_result_checker.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_pkg.sv
// Shared widths and helpers for the SHA-256 mining datapath
// (pipeline, nonce generator and result checker).
package sha_pkg;

  localparam int DIGEST_W = 256;
  localparam int NONCE_W  = 32;
  localparam int ENTRY_W  = NONCE_W + DIGEST_W;

  // The pipeline emits the digest little-endian by byte; the hash value is its byte reversal.
  function automatic logic [DIGEST_W-1:0] byte_rev256(input logic [DIGEST_W-1:0] d);
    logic [DIGEST_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGEST_W / 8; i++) begin
      r[i*8 +: 8] = d[DIGEST_W-8-i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha_result_checker_if.sv
// Job, pipeline-result and result-FIFO signals of the SHA result checker.
// master = controller/host side, slave = checker.
interface sha_result_checker_if #(
  parameter int CNT_W = 16
);

  logic                         job_load;
  logic [sha_pkg::NONCE_W-1:0]  nonce_base;
  logic [sha_pkg::DIGEST_W-1:0] target;
  logic                         valid_in;
  logic [sha_pkg::DIGEST_W-1:0] digest_in;
  logic                         res_valid;
  logic                         res_ready;
  logic [sha_pkg::NONCE_W-1:0]  res_nonce;
  logic [sha_pkg::DIGEST_W-1:0] res_digest;
  logic [CNT_W-1:0]             hit_count;
  logic                         overflow;
  logic                         busy;

  modport master (
    output job_load, nonce_base, target, valid_in, digest_in, res_ready,
    input  res_valid, res_nonce, res_digest, hit_count, overflow, busy
  );

  modport slave (
    input  job_load, nonce_base, target, valid_in, digest_in, res_ready,
    output res_valid, res_nonce, res_digest, hit_count, overflow, busy
  );

endinterface

// File: rtl/sha_result_fifo.sv
// Synchronous first-word-fall-through FIFO for {nonce, digest} result entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module sha_result_fifo #(
  parameter int WIDTH = 288,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sha_result_checker.sv
// Rebuilds the nonce of every pipeline digest, compares the hash against the job
// target in two register stages and queues winning (nonce, digest) pairs for the host.
module sha_result_checker
  import sha_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  sha_result_checker_if.slave bus
);

  logic [NONCE_W-1:0]  nonce_ctr_q, nonce_ctr_d;
  logic [DIGEST_W-1:0] target_q;

  logic                a_valid_q;
  logic [NONCE_W-1:0]  a_nonce_q;
  logic [DIGEST_W-1:0] a_digest_q;
  logic                a_hi_lt_q, a_hi_eq_q, a_lo_le_q;

  logic                b_valid_q;
  logic                b_hit_q;
  logic [NONCE_W-1:0]  b_nonce_q;
  logic [DIGEST_W-1:0] b_digest_q;

  logic [CNT_W-1:0]    hit_count_q, hit_count_d;
  logic                overflow_q, overflow_d;

  logic [DIGEST_W-1:0] h_in;
  logic                capture;
  logic                push;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_rdata;

  assign h_in    = byte_rev256(bus.digest_in);
  assign capture = bus.valid_in & ~bus.job_load;
  // In-flight compares belong to the old job and are discarded on job_load.
  assign push    = b_valid_q & b_hit_q & ~bus.job_load;
  assign drop    = push & fifo_full & ~bus.res_ready;

  always_comb begin
    nonce_ctr_d = nonce_ctr_q;
    if (bus.job_load) begin
      nonce_ctr_d = bus.nonce_base;
    end else if (bus.valid_in) begin
      nonce_ctr_d = nonce_ctr_q + NONCE_W'(1);
    end
  end

  always_comb begin
    hit_count_d = hit_count_q;
    overflow_d  = overflow_q | drop;
    if (bus.job_load) begin
      hit_count_d = '0;
      overflow_d  = 1'b0;
    end else if (push && hit_count_q != {CNT_W{1'b1}}) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      nonce_ctr_q <= '0;
      target_q    <= '0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      hit_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      nonce_ctr_q <= nonce_ctr_d;
      if (bus.job_load) begin
        target_q <= bus.target;
      end
      a_valid_q   <= capture;
      b_valid_q   <= a_valid_q & ~bus.job_load;
      hit_count_q <= hit_count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    a_nonce_q  <= nonce_ctr_q;
    a_digest_q <= bus.digest_in;
    a_hi_lt_q  <= (h_in[DIGEST_W-1:DIGEST_W/2] <  target_q[DIGEST_W-1:DIGEST_W/2]);
    a_hi_eq_q  <= (h_in[DIGEST_W-1:DIGEST_W/2] == target_q[DIGEST_W-1:DIGEST_W/2]);
    a_lo_le_q  <= (h_in[DIGEST_W/2-1:0]        <= target_q[DIGEST_W/2-1:0]);
    b_nonce_q  <= a_nonce_q;
    b_digest_q <= a_digest_q;
    b_hit_q    <= a_hi_lt_q | (a_hi_eq_q & a_lo_le_q);
  end

  sha_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .wdata_i ({b_nonce_q, b_digest_q}),
    .pop_i   (bus.res_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.res_valid  = ~fifo_empty;
  assign bus.res_nonce  = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1:DIGEST_W];
  assign bus.res_digest = fifo_empty ? '0 : fifo_rdata[DIGEST_W-1:0];
  assign bus.hit_count  = hit_count_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = a_valid_q | b_valid_q;

endmodule

// File: tb/tb_sha_result_checker.sv
// Scoreboard bench for sha_result_checker: expected hits are queued as beats are
// driven and compared against the FIFO head as entries are popped.
`timescale 1ns/1ps
module tb_sha_result_checker;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_result_checker_if #(.CNT_W(CW)) bus();

  sha_result_checker #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [287:0] exp_q[$];
  logic [31:0]  m_nonce;
  logic [255:0] m_tgt;
  int           m_hits;
  logic         m_ovf;
  int           pop_credit = 0;

  function automatic logic [255:0] rev(input logic [255:0] d);
    logic [255:0] r;
    r = {<<8{d}};
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive one pipeline beat now and update the reference model.
  task automatic set_beat(input logic v, input logic [255:0] d);
    logic [255:0] h;
    bus.valid_in  = v;
    bus.digest_in = d;
    if (v) begin
      h = rev(d);
      if (h <= m_tgt) begin
        m_hits++;
        if (exp_q.size() < DEPTH + pop_credit) exp_q.push_back({m_nonce, d});
        else m_ovf = 1'b1;
      end
      m_nonce = m_nonce + 32'd1;
    end
  endtask

  task automatic step_beat(input logic v, input logic [255:0] d);
    @(negedge clk);
    set_beat(v, d);
  endtask

  task automatic load_job(input logic [31:0] base, input logic [255:0] tgt);
    @(negedge clk);
    bus.job_load   = 1'b1;
    bus.nonce_base = base;
    bus.target     = tgt;
    bus.valid_in   = 1'b0;
    m_nonce = base;
    m_tgt   = tgt;
    m_hits  = 0;
    m_ovf   = 1'b0;
    @(negedge clk);
    bus.job_load = 1'b0;
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_settle: busy=%0b required 0 within 20 cycles", tag, bus.busy);
    end
  endtask

  task automatic pop_one(output logic v, output logic [287:0] got);
    @(negedge clk);
    v   = bus.res_valid;
    got = {bus.res_nonce, bus.res_digest};
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.job_load = 1'b0; bus.nonce_base = '0; bus.target = '0;
    bus.valid_in = 1'b0; bus.digest_in = '0; bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.overflow, bus.busy} !== 3'b000 || bus.hit_count !== '0 ||
        bus.res_nonce !== '0 || bus.res_digest !== '0) begin
      errors++;
      $display("FAIL reset: valid=%0b ovf=%0b busy=%0b hits=%0d nonce=%h required all 0",
               bus.res_valid, bus.overflow, bus.busy, bus.hit_count, bus.res_nonce);
    end
    rst = 1'b0;
    m_nonce = '0; m_tgt = '0; m_hits = 0; m_ovf = 1'b0;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_hits_all_ones();
    logic v; logic [287:0] got, e;
    load_job(32'h1000, {256{1'b1}});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        checks++;
        if (bus.res_valid !== (i == 3)) begin
          errors++;
          $display("FAIL t1_latency cycle %0d: res_valid=%0b required %0b", i, bus.res_valid, (i == 3));
        end
      end
      if (i < 3) set_beat(1'b1, rnd256()); else set_beat(1'b0, '0);
    end
    settle("t1");
    checks++;
    if (bus.hit_count !== 16'd3) begin
      errors++; $display("FAIL t1_hit_count: got %0d required 3", bus.hit_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, got);
      checks++;
      if (v !== 1'b1 || got !== e) begin
        errors++; $display("FAIL t1_pop: valid=%0b nonce=%h digest=%h required nonce=%h digest=%h", v, got[287:256], got[255:0], e[287:256], e[255:0]);
      end
      $display("t1 pop nonce=%h", got[287:256]);
    end
  endtask

  task automatic test_no_hit_target_zero();
    logic v; logic [287:0] got, e;
    load_job(32'h2000, '0);
    for (int i = 0; i < 10; i++) step_beat(1'b1, rnd256() | 256'd1);
    step_beat(1'b0, '0);
    settle("t2a");
    checks++;
    if (bus.res_valid !== 1'b0 || bus.hit_count !== '0) begin
      errors++; $display("FAIL t2_no_hit: valid=%0b hits=%0d required 0/0", bus.res_valid, bus.hit_count);
    end
    step_beat(1'b1, '0);
    step_beat(1'b0, '0);
    settle("t2b");
    checks++;
    if (bus.hit_count !== CW'(m_hits)) begin
      errors++; $display("FAIL t2_hit_count: got %0d required %0d", bus.hit_count, m_hits);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, got);
      checks++;
      if (v !== 1'b1 || got !== e) begin
        errors++; $display("FAIL t2_pop: valid=%0b nonce=%h required %h", v, got[287:256], e[287:256]);
      end
      $display("t2 pop nonce=%h", got[287:256]);
    end
  endtask

  task automatic test_boundary();
    logic v; logic [287:0] got, e;
    logic [255:0] t;
    t = rnd256();
    t[255:248] = 8'h7F;
    t[127:120] = 8'h7F;
    load_job(32'h3000, t);
    step_beat(1'b1, rev(t));                                   // equal: hit
    step_beat(1'b1, rev(t + 256'd1));                          // one above: miss
    step_beat(1'b1, rev({t[255:128], t[127:0] + 128'd5}));     // hi equal, lo greater: miss
    step_beat(1'b1, rev(t - 256'd1));                          // one below: hit
    step_beat(1'b1, rev({t[255:128] - 128'd1, {128{1'b1}}}));  // hi less, lo max: hit
    step_beat(1'b1, rev({t[255:128] + 128'd1, 128'd0}));       // hi greater: miss
    step_beat(1'b0, '0);
    settle("t3");
    checks++;
    if (bus.hit_count !== 16'd3) begin
      errors++; $display("FAIL t3_hit_count: got %0d required 3", bus.hit_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, got);
      checks++;
      if (v !== 1'b1 || got !== e) begin
        errors++; $display("FAIL t3_pop: valid=%0b nonce=%h required %h", v, got[287:256], e[287:256]);
      end
      $display("t3 pop nonce=%h", got[287:256]);
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL t3_drained: res_valid=%0b required 0", bus.res_valid);
    end
  endtask

  task automatic test_overflow();
    logic v; logic [287:0] got, e;
    load_job(32'h4000, {256{1'b1}});
    for (int i = 0; i < 6; i++) step_beat(1'b1, rnd256());
    step_beat(1'b0, '0);
    settle("t4");
    checks++;
    if (bus.overflow !== m_ovf || bus.hit_count !== 16'd6) begin
      errors++; $display("FAIL t4_overflow: ovf=%0b hits=%0d required %0b/6", bus.overflow, bus.hit_count, m_ovf);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, got);
      checks++;
      if (v !== 1'b1 || got !== e) begin
        errors++; $display("FAIL t4_pop: valid=%0b nonce=%h required %h", v, got[287:256], e[287:256]);
      end
      $display("t4 pop nonce=%h", got[287:256]);
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL t4_after_drain: valid=%0b ovf=%0b required 0/1", bus.res_valid, bus.overflow);
    end
    load_job(32'h4100, {256{1'b1}});
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL t4_job_clear: ovf=%0b required 0", bus.overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic v; logic [287:0] got, e;
    load_job(32'h5000, {256{1'b1}});
    for (int i = 0; i < 4; i++) step_beat(1'b1, rnd256());
    step_beat(1'b0, '0);
    settle("t5a");
    pop_credit = 1;
    step_beat(1'b1, rnd256());
    step_beat(1'b0, '0);
    @(negedge clk);
    v = bus.res_valid;
    got = {bus.res_nonce, bus.res_digest};
    e = exp_q.pop_front();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    pop_credit = 0;
    checks++;
    if (v !== 1'b1 || got !== e) begin
      errors++; $display("FAIL t5_head: valid=%0b nonce=%h required %h", v, got[287:256], e[287:256]);
    end
    settle("t5b");
    checks++;
    if (bus.overflow !== 1'b0 || bus.hit_count !== 16'd5) begin
      errors++; $display("FAIL t5_no_overflow: ovf=%0b hits=%0d required 0/5", bus.overflow, bus.hit_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, got);
      checks++;
      if (v !== 1'b1 || got !== e) begin
        errors++; $display("FAIL t5_pop: valid=%0b nonce=%h required %h", v, got[287:256], e[287:256]);
      end
      $display("t5 pop nonce=%h", got[287:256]);
    end
    pop_one(v, got);
    @(negedge clk);
    checks++;
    if (v !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL t5_pop_empty: valid=%0b/%0b required 0", v, bus.res_valid);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic v; logic [287:0] got, e;
    load_job(32'hFFFF_FFFF, {256{1'b1}});
    step_beat(1'b1, rnd256());
    step_beat(1'b1, rnd256());
    step_beat(1'b0, '0);
    settle("t6a");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, got);
      checks++;
      if (v !== 1'b1 || got !== e) begin
        errors++; $display("FAIL t6_wrap_pop: valid=%0b nonce=%h required %h", v, got[287:256], e[287:256]);
      end
      $display("t6 pop nonce=%h", got[287:256]);
    end
    for (int i = 0; i < 4; i++) step_beat(1'b1, rnd256());
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL t6_pre_reset: valid=%0b busy=%0b required 1/1", bus.res_valid, bus.busy);
    end
    rst = 1'b1;
    set_beat(1'b0, '0);
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.hit_count !== '0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL t6_mid_reset: valid=%0b hits=%0d busy=%0b ovf=%0b required 0", bus.res_valid, bus.hit_count, bus.busy, bus.overflow);
    end
    rst = 1'b0;
    exp_q.delete();
    m_nonce = '0; m_tgt = '0; m_hits = 0; m_ovf = 1'b0;
    step_beat(1'b1, '0);
    step_beat(1'b0, '0);
    settle("t6b");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(v, got);
      checks++;
      if (v !== 1'b1 || got !== e) begin
        errors++; $display("FAIL t6_post_reset_pop: valid=%0b nonce=%h required %h", v, got[287:256], e[287:256]);
      end
      $display("t6 post-reset pop nonce=%h", got[287:256]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hits_all_ones();
    test_no_hit_target_zero();
    test_boundary();
    test_overflow();
    test_full_push_pop();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
